// File: rtl/heptagon_feeder_pkg.sv
// Shared types and sizing for the heptagon feeder and its result checker.
package heptagon_feeder_pkg;

  localparam int NUM_HEPT = 5;
  localparam int NUM_PTS  = 7;
  localparam int PT_TOTAL = NUM_HEPT * NUM_PTS;
  localparam int COORD_W  = 10;
  localparam int AREA_W   = 19;
  localparam int TIMEOUT  = 1023;
  localparam int WDOG_W   = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    GAP  = 3'd2,
    SEND = 3'd3,
    WAIT = 3'd4,
    DONE = 3'd5
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef struct packed {
    logic [2:0]        index;
    logic [AREA_W-1:0] area;
  } result_t;

endpackage

// File: rtl/heptagon_feeder_result_checker.sv
// Result checker: flags rising areas, out-of-range indices and repeated indices.
// Sticky flag, cleared when a new frame starts.
module hept_result_checker
  import heptagon_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              capture,
  input  logic              first,
  input  logic [2:0]        index,
  input  logic [AREA_W-1:0] area,
  output logic              order_err
);

  logic [NUM_HEPT-1:0] seen;
  logic [AREA_W-1:0]   prev_area;
  logic [7:0]          idx_dec;
  logic                idx_bad;
  logic                area_bad;

  // One-hot of the incoming index; bits above 4 mean the index is out of range.
  assign idx_dec  = 8'd1 << index;
  assign idx_bad  = (|idx_dec[7:NUM_HEPT]) || (|(idx_dec[NUM_HEPT-1:0] & seen));
  assign area_bad = !first && (area > prev_area);

  // Track seen mask and last area; latch any violation until the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen      <= '0;
      prev_area <= '0;
      order_err <= 1'b0;
    end else if (clear) begin
      seen      <= '0;
      prev_area <= '0;
      order_err <= 1'b0;
    end else if (capture) begin
      seen      <= seen | idx_dec[NUM_HEPT-1:0];
      prev_area <= area;
      if (idx_bad || area_bad) order_err <= 1'b1;
    end
  end

endmodule

// File: rtl/heptagon_feeder.sv
// Heptagon feeder: streams 35 preloaded vertices into the area-sort engine,
// drives the engine reset and captures the five sorted results.
// Optional result checker compiled in with HEPT_FEEDER_CHECK_EN.
//
// state | meaning
// IDLE  | loader access, waiting for start
// RST   | engine reset pulse (one cycle)
// GAP   | engine post-reset idle cycle, X/Y = 0
// SEND  | one vertex per cycle, 35 cycles
// WAIT  | capture results, watchdog running
// DONE  | one-cycle done pulse
module heptagon_feeder
  import heptagon_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [5:0]         load_addr,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               start,
  output logic               busy,
  output logic               hep_rst,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic               valid,
  input  logic [2:0]         Index,
  input  logic [AREA_W-1:0]  Area,
  input  logic [2:0]         rd_addr,
  output logic [2:0]         rd_index,
  output logic [AREA_W-1:0]  rd_area,
  output logic               done,
  output logic               timeout,
  output logic               order_err
);

  localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(TIMEOUT - 1);
  localparam logic [5:0]        PT_LAST   = 6'(PT_TOTAL - 1);

  state_e            state;
  state_e            state_nx;
  point_t            pts [PT_TOTAL];
  result_t           res [NUM_HEPT];
  logic [5:0]        pt_idx;
  logic [2:0]        res_cnt;
  logic [WDOG_W-1:0] wdog;
  logic              frame_start;
  logic              capture;
  logic              last_cap;
  logic              wdog_tc;

  assign frame_start = (state == IDLE) && start;
  assign capture     = (state == WAIT) && valid && (res_cnt < 3'(NUM_HEPT));
  assign last_cap    = capture && (res_cnt == 3'(NUM_HEPT - 1));
  // The watchdog hits terminal count on the TIMEOUT-th WAIT cycle.
  assign wdog_tc     = (state == WAIT) && (wdog == '0);

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign X    = (state == SEND) ? pts[pt_idx].x : '0;
  assign Y    = (state == SEND) ? pts[pt_idx].y : '0;

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RST;
      RST:     state_nx = GAP;
      GAP:     state_nx = SEND;
      SEND:    if (pt_idx == PT_LAST) state_nx = WAIT;
      WAIT:    if (last_cap || wdog_tc) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, engine reset, point index, watchdog, result count and timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hep_rst <= 1'b1;
      pt_idx  <= '0;
      wdog    <= '0;
      res_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      hep_rst <= (state_nx == RST);
      pt_idx  <= (state == SEND) ? pt_idx + 6'd1 : 6'd0;
      if (state == SEND) begin
        wdog <= WDOG_LOAD;
      end else if ((state == WAIT) && (wdog != '0)) begin
        wdog <= wdog - 1'b1;
      end
      if (frame_start) begin
        res_cnt <= '0;
        timeout <= 1'b0;
      end else begin
        if (capture) res_cnt <= res_cnt + 3'd1;
        // A capture completing the frame on the expiry cycle takes priority.
        if (wdog_tc && !last_cap) timeout <= 1'b1;
      end
    end
  end

  // Point buffer: loader writes only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && load_en && (load_addr < 6'(PT_TOTAL))) begin
      pts[load_addr] <= '{x: load_x, y: load_y};
    end
  end

  // Result buffer capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_HEPT; i++) res[i] <= '0;
    end else if (capture) begin
      res[res_cnt] <= '{index: Index, area: Area};
    end
  end

  // Combinational result read; unused slots read as zero.
  always_comb begin
    rd_index = '0;
    rd_area  = '0;
    if (rd_addr < 3'(NUM_HEPT)) begin
      rd_index = res[rd_addr].index;
      rd_area  = res[rd_addr].area;
    end
  end

`ifdef HEPT_FEEDER_CHECK_EN
  hept_result_checker u_checker (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (frame_start),
    .capture   (capture),
    .first     (res_cnt == 3'd0),
    .index     (Index),
    .area      (Area),
    .order_err (order_err)
  );
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_heptagon_feeder.sv
// Directed bench for heptagon_feeder: frame streaming, capture, checker,
// timeout, ignored inputs and mid-frame reset.
module tb_heptagon_feeder;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [9:0]  load_x;
  logic [9:0]  load_y;
  logic        start;
  logic        busy;
  logic        hep_rst;
  logic [9:0]  X;
  logic [9:0]  Y;
  logic        valid;
  logic [2:0]  Index;
  logic [18:0] Area;
  logic [2:0]  rd_addr;
  logic [2:0]  rd_index;
  logic [18:0] rd_area;
  logic        done;
  logic        timeout;
  logic        order_err;

  int checks = 0;
  int errors = 0;

  logic [2:0]  res_i [5];
  logic [18:0] res_a [5];
  logic [2:0]  exp_ri [5];
  logic [18:0] exp_ra [5];

  heptagon_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_x    (load_x),
    .load_y    (load_y),
    .start     (start),
    .busy      (busy),
    .hep_rst   (hep_rst),
    .X         (X),
    .Y         (Y),
    .valid     (valid),
    .Index     (Index),
    .Area      (Area),
    .rd_addr   (rd_addr),
    .rd_index  (rd_index),
    .rd_area   (rd_area),
    .done      (done),
    .timeout   (timeout),
    .order_err (order_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_oerr(input int n);
    bit [7:0] seen;
    bit       bad;
    seen = '0;
    bad  = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (res_i[i] > 3'd4 || seen[res_i[i]]) bad = 1'b1;
      seen[res_i[i]] = 1'b1;
      if (i > 0 && res_a[i] > res_a[i-1]) bad = 1'b1;
    end
    return bad;
  endfunction

  // Reads every result slot plus two out-of-range slots; realigns to negedge.
  task automatic chk_results(input string tag);
    for (int r = 0; r < 8; r++) begin
      if (r == 6) continue;
      rd_addr = 3'(r);
      #1;
      if (r < 5) begin
        chk($sformatf("%s_rd_idx%0d", tag, r), rd_index, exp_ri[r]);
        chk($sformatf("%s_rd_area%0d", tag, r), rd_area, exp_ra[r]);
      end else begin
        chk($sformatf("%s_rd_idx%0d", tag, r), rd_index, 0);
        chk($sformatf("%s_rd_area%0d", tag, r), rd_area, 0);
      end
    end
    rd_addr = 3'd0;
    @(negedge clk);
  endtask

  // Runs one frame from IDLE; engine returns nres results (0 = never valid).
  task automatic run_frame(input int nres, input string tag);
    int done_t;
    int done_cnt;
    bit exp_oerr;
`ifdef HEPT_FEEDER_CHECK_EN
    exp_oerr = model_oerr(nres);
`else
    exp_oerr = 1'b0;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_rst_hep"}, hep_rst, 1);
    chk({tag, "_rst_busy"}, busy, 1);
    chk({tag, "_rst_x"}, X, 0);
    chk({tag, "_rst_to_clr"}, timeout, 0);
    chk({tag, "_rst_oerr_clr"}, order_err, 0);
    @(negedge clk);
    chk({tag, "_gap_hep"}, hep_rst, 0);
    chk({tag, "_gap_x"}, X, 0);
    chk({tag, "_gap_y"}, Y, 0);
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      chk($sformatf("%s_x%0d", tag, k), X, k);
      chk($sformatf("%s_y%0d", tag, k), Y, 2 * k);
      load_en   = (k == 10);
      load_addr = 6'd5;
      load_x    = 10'd999;
      load_y    = 10'd999;
    end
    load_en = 1'b0;
    @(negedge clk);
    chk({tag, "_wait_x"}, X, 0);
    chk({tag, "_wait_busy"}, busy, 1);
    done_t   = -1;
    done_cnt = 0;
    for (int t = 0; t < 1100; t++) begin
      if (t > 0) @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        done_t = t;
      end
      if (t < nres) begin
        valid = 1'b1;
        Index = res_i[t];
        Area  = res_a[t];
      end else if (t == nres && nres > 0) begin
        valid = 1'b1;
        Index = 3'd7;
        Area  = 19'h7FFFF;
      end else begin
        valid = 1'b0;
      end
      start = (t == 1);
      if (done_cnt > 0 && t == done_t + 1) break;
    end
    valid = 1'b0;
    start = 1'b0;
    chk({tag, "_done_t"}, done_t, (nres == 5) ? 5 : 1023);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_idle_done"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_timeout"}, timeout, (nres == 5) ? 0 : 1);
    chk({tag, "_oerr"}, order_err, exp_oerr);
    if (nres == 5) begin
      for (int i = 0; i < 5; i++) begin
        exp_ri[i] = res_i[i];
        exp_ra[i] = res_a[i];
      end
    end
    chk_results(tag);
    chk({tag, "_oerr_sticky"}, order_err, exp_oerr);
    chk({tag, "_still_idle"}, busy, 0);
  endtask

  initial begin
    reset     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_x    = '0;
    load_y    = '0;
    start     = 1'b0;
    valid     = 1'b0;
    Index     = '0;
    Area      = '0;
    rd_addr   = '0;
    for (int i = 0; i < 5; i++) begin
      exp_ri[i] = '0;
      exp_ra[i] = '0;
    end

    #12;
    chk("por_hep_rst", hep_rst, 1);
    chk("por_busy", busy, 0);
    chk("por_x", X, 0);
    chk("por_done", done, 0);
    chk("por_timeout", timeout, 0);
    chk("por_oerr", order_err, 0);
    chk("por_rd_area", rd_area, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_hep_rst", hep_rst, 0);
    chk("rel_busy", busy, 0);

    for (int a = 0; a < 35; a++) begin
      load_en   = 1'b1;
      load_addr = 6'(a);
      load_x    = 10'(a);
      load_y    = 10'(2 * a);
      @(negedge clk);
    end
    load_en = 1'b0;
    @(negedge clk);

    res_i = '{3'd3, 3'd1, 3'd4, 3'd0, 3'd2};
    res_a = '{19'd500, 19'd400, 19'd300, 19'd200, 19'd100};
    run_frame(5, "basic");

    res_i = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    res_a = '{19'd100, 19'd200, 19'd50, 19'd40, 19'd30};
    run_frame(5, "rise");

    run_frame(0, "tmo");

    res_i = '{3'd2, 3'd2, 3'd0, 3'd1, 3'd3};
    res_a = '{19'd500, 19'd400, 19'd300, 19'd200, 19'd100};
    run_frame(5, "dup");

    // Mid-frame reset at point 17.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int k = 0; k <= 17; k++) @(negedge clk);
    chk("mr_pt17_x", X, 17);
    reset = 1'b0;
    #1;
    chk("mr_hep_rst", hep_rst, 1);
    chk("mr_busy", busy, 0);
    chk("mr_x", X, 0);
    chk("mr_y", Y, 0);
    chk("mr_done", done, 0);
    chk("mr_oerr", order_err, 0);
    chk("mr_rd_area", rd_area, 0);
    chk("mr_rd_idx", rd_index, 0);
    @(negedge clk);
    chk("mr_hold_done", done, 0);
    chk("mr_hold_hep", hep_rst, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rel_hep", hep_rst, 0);
    chk("mr_rel_done", done, 0);
    chk("mr_rel_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      exp_ri[i] = '0;
      exp_ra[i] = '0;
    end

    res_i = '{3'd3, 3'd1, 3'd4, 3'd0, 3'd2};
    res_a = '{19'd500, 19'd400, 19'd300, 19'd200, 19'd100};
    run_frame(5, "replay");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/heptagon_feeder.md
# heptagon_feeder

Host-side driver for the heptagon area-sort engine: holds 35 preloaded vertices (5 heptagons × 7 points) and streams them one per cycle on the engine's X/Y inputs. It also generates the engine's reset, then captures the five sorted (Index, Area) results into a readable buffer. It sits between a loader or test controller and the heptagon engine, and optionally checks result ordering and index uniqueness.

## Interface
- NUM_HEPT, 5, heptagons per frame
- NUM_PTS, 7, vertices per heptagon
- COORD_W, 10, coordinate width (unsigned)
- AREA_W, 19, area width
- TIMEOUT, 1023, max cycles in WAIT before abort
- clk  in  1  clock
- reset  in  1  reset; one clock, asynchronous and active-low
- load_en  in  1  write strobe for point buffer
- load_addr  in  6  point slot 0..34 (heptagon*7+point)
- load_x / load_y  in  COORD_W  vertex coordinates
- start  in  1  begin a frame (level sampled in IDLE)
- busy  out  1  high from RST through DONE
- hep_rst  out  1  active-high reset to the engine
- X / Y  out  COORD_W  vertex stream to the engine
- valid  in  1  engine result strobe
- Index  in  3  engine result index
- Area  in  AREA_W  engine result area
- rd_addr  in  3  result slot select 0..4
- rd_index  out  3  combinational read of captured index
- rd_area  out  AREA_W  combinational read of captured area
- done  out  1  one-cycle pulse at end of frame
- timeout  out  1  sticky, set if WAIT expires; cleared on start
- order_err  out  1  sticky checker flag; cleared on start

## Operation
- States: IDLE → RST → GAP → SEND → WAIT → DONE → IDLE.
- IDLE:
  - load_en writes buf[load_addr]; addresses ≥35 are ignored.
  - start=1 moves to RST and clears res_cnt, timeout and order_err.
- RST: hep_rst=1 for exactly one cycle.
- GAP: hep_rst=0, X/Y=0 for one cycle (the engine's post-reset idle cycle).
- SEND: cycle k (k=0..34) drives X/Y=buf[k]. After k=34, go to WAIT.
- WAIT:
  - Each cycle with valid=1 and res_cnt<5 stores Index/Area into res[res_cnt] and increments res_cnt.
  - On the 5th capture, go to DONE.
  - A 10-bit watchdog counts WAIT cycles. On reaching TIMEOUT, set timeout and go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Ignored inputs:
  - load_en and start while busy.
  - valid outside WAIT, and valid after 5 captures.
- X/Y are 0 in every state except SEND.
- The point buffer has no reset. The result buffer resets to 0.
- rd_addr ≥5 returns 0.

## Timing
- Reset values: busy=0, hep_rst=1 (holds the engine in reset while the feeder is in reset), X=Y=0, done=0, timeout=0, order_err=0, rd outputs 0. The state returns to IDLE.
- After reset releases, hep_rst drops to 0 on the first clock edge.
- Let start be sampled at edge 0:
  - RST is cycle 1.
  - GAP is cycle 2.
  - Points 0..34 are on X/Y in cycles 3..37.
  - WAIT begins at cycle 38.
- Result capture latency: same edge as valid. rd_* reflect the capture the following cycle.
- done follows the 5th capture (or timeout) by one cycle.
- Simultaneous valid and timeout expiry in the same cycle: the capture wins, and timeout is set only if res_cnt is still <5 after the capture.
- Reset mid-frame aborts immediately. No done pulse is produced.

## Configuration
- HEPT_FEEDER_CHECK_EN defined: the result checker is compiled in. order_err is set on either of these:
  - Area[k] > Area[k-1] (results must be non-increasing).
  - An Index outside 0..4, or a repeated Index, tracked with a 5-bit seen mask.
- Without HEPT_FEEDER_CHECK_EN: order_err is tied to 0 and no checker logic exists.

## Structure
- Shared package holds:
  - The state enum (IDLE, RST, GAP, SEND, WAIT, DONE).
  - NUM_HEPT, NUM_PTS, total point count 35, COORD_W, AREA_W.
- One sub-module, hept_result_checker, contains the order comparator and seen mask. It is instantiated only under HEPT_FEEDER_CHECK_EN.

## Test plan
- **Basic frame:**
  - Stimulus: load 35 points with x=addr, y=2*addr, then start.
  - Response: hep_rst high in cycle 1; X=0..34 and Y=0..68 on cycles 3..37; busy=1 in cycles 1..38+.
- **Capture:**
  - Stimulus: a model engine returns (3,500),(1,400),(4,300),(0,200),(2,100) on consecutive valids.
  - Response: rd_addr 0..4 reads exactly these; done pulses once; order_err=0.
- **Checker:**
  - Stimulus: results (0,100),(1,200) or a repeated Index 2.
  - Response: order_err=1 sticky until the next start. With the macro undefined, order_err stays 0.
- **Timeout:**
  - Stimulus: the engine never asserts valid.
  - Response: timeout=1 and done pulses 1023 cycles after WAIT entry; state returns to IDLE.
- **Ignored inputs:**
  - Stimulus: load_en during SEND, start during WAIT, a 6th valid.
  - Response: the buffer, state and results are unchanged.
- **Mid-frame reset:**
  - Stimulus: assert reset at point 17.
  - Response: all outputs at reset values asynchronously, hep_rst=1, no done. A subsequent start replays the full frame from the retained point buffer.
